// File: rtl/bfloat16_mac_tree_pipe.sv
// Pipelined bfloat16 dot-product engine: multiplier row, registered adder
// tree, and a group accumulator with valid/ready handshakes on both sides.

module bfloat16_multiplier (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y
);
    logic              sy;
    logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [15:0]       prod;
    logic [6:0]        mant;
    logic              grd, stk, rnd;
    logic [7:0]        mant_r;
    logic signed [9:0] exp_n, exp_r;

    // Subnormal inputs and results flush to signed zero; rounding is RNE.
    always_comb begin
        sy     = a[15] ^ b[15];
        a_zero = a[14:7] == 8'd0;
        b_zero = b[14:7] == 8'd0;
        a_inf  = (a[14:7] == 8'hFF) && (a[6:0] == 7'd0);
        b_inf  = (b[14:7] == 8'hFF) && (b[6:0] == 7'd0);
        a_nan  = (a[14:7] == 8'hFF) && (a[6:0] != 7'd0);
        b_nan  = (b[14:7] == 8'hFF) && (b[6:0] != 7'd0);
        prod   = {1'b1, a[6:0]} * {1'b1, b[6:0]};
        exp_n  = $signed({2'b00, a[14:7]}) + $signed({2'b00, b[14:7]})
               - 10'sd127;
        if (prod[15]) begin
            mant  = prod[14:8];
            grd   = prod[7];
            stk   = |prod[6:0];
            exp_n = exp_n + 10'sd1;
        end else begin
            mant  = prod[13:7];
            grd   = prod[6];
            stk   = |prod[5:0];
        end
        rnd    = grd & (stk | mant[0]);
        mant_r = {1'b0, mant} + {7'd0, rnd};
        exp_r  = exp_n + $signed({9'd0, mant_r[7]});
        y      = {sy, exp_r[7:0], mant_r[6:0]};
        if (exp_r > 10'sd254) begin
            y = {sy, 8'hFF, 7'd0};
        end else if (exp_r < 10'sd1) begin
            y = {sy, 15'd0};
        end
        if (a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero)) begin
            y = 16'h7FC0;
        end else if (a_inf | b_inf) begin
            y = {sy, 8'hFF, 7'd0};
        end else if (a_zero | b_zero) begin
            y = {sy, 15'd0};
        end
    end
endmodule

module bfloat16_adder (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y
);
    logic              swap, big_s, eff_sub, stk_in;
    logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [7:0]        big_e, sml_e, d;
    logic [6:0]        big_m, sml_m, mant;
    logic [17:0]       big_x, sml_x;
    logic [35:0]       wide;
    logic [18:0]       sum, norm;
    logic [4:0]        msb;
    logic              grd, stk, rnd;
    logic [7:0]        mant_r;
    logic signed [9:0] exp_n, exp_r;

    function automatic logic [4:0] msb19(input logic [18:0] v);
        msb19 = 5'd0;
        for (int i = 0; i < 19; i++) begin
            if (v[i]) msb19 = i[4:0];
        end
    endfunction

    always_comb begin
        a_zero  = a[14:7] == 8'd0;
        b_zero  = b[14:7] == 8'd0;
        a_inf   = (a[14:7] == 8'hFF) && (a[6:0] == 7'd0);
        b_inf   = (b[14:7] == 8'hFF) && (b[6:0] == 7'd0);
        a_nan   = (a[14:7] == 8'hFF) && (a[6:0] != 7'd0);
        b_nan   = (b[14:7] == 8'hFF) && (b[6:0] != 7'd0);
        swap    = b[14:0] > a[14:0];
        big_s   = swap ? b[15]   : a[15];
        big_e   = swap ? b[14:7] : a[14:7];
        big_m   = swap ? b[6:0]  : a[6:0];
        sml_e   = swap ? a[14:7] : b[14:7];
        sml_m   = swap ? a[6:0]  : b[6:0];
        d       = big_e - sml_e;
        eff_sub = a[15] ^ b[15];
        big_x   = {1'b1, big_m, 10'd0};
        wide    = {1'b1, sml_m, 10'd0, 18'd0} >> d;
        // Bits shifted past the guard field collapse into one sticky LSB.
        if (d > 8'd17) begin
            sml_x  = 18'd0;
            stk_in = 1'b1;
        end else begin
            sml_x  = wide[35:18];
            stk_in = |wide[17:0];
        end
        sml_x = sml_x | {17'd0, stk_in};
        if (eff_sub) begin
            sum = {1'b0, big_x} - {1'b0, sml_x};
        end else begin
            sum = {1'b0, big_x} + {1'b0, sml_x};
        end
        msb    = msb19(sum);
        norm   = sum << (5'd18 - msb);
        exp_n  = $signed({2'b00, big_e}) + $signed({5'd0, msb}) - 10'sd17;
        mant   = norm[17:11];
        grd    = norm[10];
        stk    = |norm[9:0];
        rnd    = grd & (stk | mant[0]);
        mant_r = {1'b0, mant} + {7'd0, rnd};
        exp_r  = exp_n + $signed({9'd0, mant_r[7]});
        y      = {big_s, exp_r[7:0], mant_r[6:0]};
        if (exp_r > 10'sd254) begin
            y = {big_s, 8'hFF, 7'd0};
        end else if (exp_r < 10'sd1) begin
            y = {big_s, 15'd0};
        end
        if (a_nan | b_nan | (a_inf & b_inf & eff_sub)) begin
            y = 16'h7FC0;
        end else if (a_inf) begin
            y = a;
        end else if (b_inf) begin
            y = b;
        end else if (a_zero & b_zero) begin
            y = {a[15] & b[15], 15'd0};
        end else if (a_zero) begin
            y = b;
        end else if (b_zero) begin
            y = a;
        end else if (!norm[18]) begin
            y = 16'h0000;
        end
    end
endmodule

module bfloat16_mac_tree_pipe #(
    parameter int NUM_PAIRS = 8,
    parameter int CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NUM_PAIRS*16-1:0] in_a,
    input  logic [NUM_PAIRS*16-1:0] in_b,
    input  logic                   in_acc,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [15:0]            out_data,
    output logic [CNT_W-1:0]       out_beats
);
    localparam int LOG2_P = $clog2(NUM_PAIRS);
    localparam int NODES  = 2 * NUM_PAIRS - 1;
    localparam int TOP    = NODES - 1;

    logic                  stall;
    logic [16*NODES-1:0]   node_d, node_q;
    logic [LOG2_P:0]       vld, accf, lastf;
    logic [15:0]           tree, acc_sum, grp_sum;
    logic [15:0]           grp_acc;
    logic [CNT_W-1:0]      grp_cnt, cnt_n;
    logic                  grp_first;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    // Node layout: leaves 0..N-1 hold products; each tree level follows.
    for (genvar k = 0; k < NUM_PAIRS; k++) begin : g_mul
        bfloat16_multiplier u_mul (
            .a (in_a[16*k +: 16]),
            .b (in_b[16*k +: 16]),
            .y (node_d[16*k +: 16])
        );
    end

    for (genvar l = 1; l <= LOG2_P; l++) begin : g_lvl
        for (genvar j = 0; j < (NUM_PAIRS >> l); j++) begin : g_add
            localparam int SRC = 2*NUM_PAIRS - ((2*NUM_PAIRS) >> (l-1)) + 2*j;
            localparam int DST = 2*NUM_PAIRS - ((2*NUM_PAIRS) >> l) + j;
            bfloat16_adder u_add (
                .a (node_q[16*SRC +: 16]),
                .b (node_q[16*(SRC+1) +: 16]),
                .y (node_d[16*DST +: 16])
            );
        end
    end

    always_ff @(posedge clk) begin
        if (!stall) begin
            node_q <= node_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld   <= '0;
            accf  <= '0;
            lastf <= '0;
        end else if (!stall) begin
            vld   <= {vld[LOG2_P-1:0], in_valid & in_ready};
            accf  <= {accf[LOG2_P-1:0], in_acc};
            lastf <= {lastf[LOG2_P-1:0], in_last};
        end
    end

    assign tree = node_q[16*TOP +: 16];

    bfloat16_adder u_acc (
        .a (grp_acc),
        .b (tree),
        .y (acc_sum)
    );

    always_comb begin
        grp_sum = grp_first ? tree : acc_sum;
        if (grp_first) begin
            cnt_n = CNT_W'(1);
        end else if (&grp_cnt) begin
            cnt_n = grp_cnt;
        end else begin
            cnt_n = grp_cnt + CNT_W'(1);
        end
    end

    // Non-accumulating beats bypass the group state so an open group survives.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= 16'd0;
            out_beats <= '0;
            grp_acc   <= 16'd0;
            grp_cnt   <= '0;
            grp_first <= 1'b1;
        end else if (!stall) begin
            out_valid <= 1'b0;
            if (vld[LOG2_P]) begin
                unique case (1'b1)
                    !accf[LOG2_P]: begin
                        out_valid <= 1'b1;
                        out_data  <= tree;
                        out_beats <= CNT_W'(1);
                    end
                    accf[LOG2_P] & lastf[LOG2_P]: begin
                        out_valid <= 1'b1;
                        out_data  <= grp_sum;
                        out_beats <= cnt_n;
                        grp_acc   <= 16'd0;
                        grp_cnt   <= '0;
                        grp_first <= 1'b1;
                    end
                    accf[LOG2_P] & !lastf[LOG2_P]: begin
                        grp_acc   <= grp_sum;
                        grp_cnt   <= cnt_n;
                        grp_first <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_bfloat16_mac_tree_pipe.sv
// Scoreboard bench for bfloat16_mac_tree_pipe using a real-arithmetic
// reference model and randomized operands, flags and backpressure.

module tb_bfloat16_mac_tree_pipe;
    localparam int NP  = 8;
    localparam int CW  = 16;
    localparam int LAT = $clog2(NP) + 2;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [NP*16-1:0]   in_a, in_b;
    logic               in_acc, in_last;
    logic               out_valid;
    logic               out_ready;
    logic [15:0]        out_data;
    logic [CW-1:0]      out_beats;

    bfloat16_mac_tree_pipe #(.NUM_PAIRS(NP), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_acc    (in_acc),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_beats (out_beats)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0]   data;
        logic [CW-1:0] beats;
    } exp_t;

    exp_t        sbq[$];
    int          n_vec, n_err;
    int          run, run_max;
    int          t_waits;
    bit          model_on;
    bit          done;
    logic [15:0] m_acc;
    int          m_cnt;
    bit          m_first;

    function automatic real bf2r(input logic [15:0] x);
        logic [10:0] e11;
        if (x[14:7] == 8'd0) return $bitstoreal({x[15], 63'd0});
        e11 = {3'b000, x[14:7]} + 11'd896;
        return $bitstoreal({x[15], e11, x[6:0], 45'd0});
    endfunction

    // Round a double to bfloat16: nearest-even, flush tiny results to zero.
    function automatic logic [15:0] r2bf(input real r);
        logic [63:0] bits;
        logic [7:0]  m8;
        int          de;
        bits = $realtobits(r);
        if (bits[62:0] == 63'd0) return {bits[63], 15'd0};
        de = int'(bits[62:52]) - 896;
        m8 = {1'b0, bits[51:45]};
        if (bits[44] && ((|bits[43:0]) || m8[0])) m8 = m8 + 8'd1;
        if (m8[7]) de = de + 1;
        if (de >= 255) return {bits[63], 8'hFF, 7'd0};
        if (de <= 0) return {bits[63], 15'd0};
        return {bits[63], de[7:0], m8[6:0]};
    endfunction

    function automatic logic [15:0] fmul(input logic [15:0] a, input logic [15:0] b);
        return r2bf(bf2r(a) * bf2r(b));
    endfunction

    function automatic logic [15:0] fadd(input logic [15:0] a, input logic [15:0] b);
        return r2bf(bf2r(a) + bf2r(b));
    endfunction

    function automatic logic [15:0] dot(input logic [NP*16-1:0] va, input logic [NP*16-1:0] vb);
        logic [15:0] p [NP];
        int n;
        for (int k = 0; k < NP; k++) p[k] = fmul(va[16*k +: 16], vb[16*k +: 16]);
        n = NP;
        while (n > 1) begin
            for (int j = 0; j < n / 2; j++) p[j] = fadd(p[2*j], p[2*j+1]);
            n = n / 2;
        end
        return p[0];
    endfunction

    function automatic logic [15:0] rnd_bf();
        if ($urandom_range(0, 9) == 0) return {1'($urandom_range(0, 1)), 15'd0};
        return {1'($urandom_range(0, 1)), 8'($urandom_range(120, 134)), 7'($urandom)};
    endfunction

    task automatic model_reset();
        m_acc   = 16'd0;
        m_cnt   = 0;
        m_first = 1'b1;
    endtask

    task automatic model_beat(input logic [NP*16-1:0] va, input logic [NP*16-1:0] vb,
                              input logic acc, input logic last);
        logic [15:0] t, s;
        exp_t e;
        t = dot(va, vb);
        if (!acc) begin
            e.data = t; e.beats = CW'(1); sbq.push_back(e);
        end else begin
            s = m_first ? t : fadd(m_acc, t);
            m_cnt = m_first ? 1 : m_cnt + 1;
            if (last) begin
                e.data = s; e.beats = CW'(m_cnt); sbq.push_back(e);
                model_reset();
            end else begin
                m_acc = s; m_first = 1'b0;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [15:0] d, input int b);
        exp_t e;
        e.data = d; e.beats = CW'(b);
        sbq.push_back(e);
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send(input logic [NP*16-1:0] va, input logic [NP*16-1:0] vb,
                        input logic acc, input logic last);
        bit ok;
        int w;
        in_a = va; in_b = vb; in_acc = acc; in_last = last; in_valid = 1'b1;
        w = 0;
        ok = 1'b0;
        while (!ok) begin
            #1;
            ok = in_ready;
            @(negedge clk);
            if (!ok) begin
                w++;
                t_waits++;
                if (w > 200) begin
                    check("send_timeout", 32'(w), 32'd0);
                    break;
                end
            end
        end
        if (ok && model_on) model_beat(va, vb, acc, last);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sbq.size() != 0 && k < 500) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        #3;
        check("drain_empty", 32'(sbq.size()), 32'd0);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!rst_n) begin
            run = 0;
        end else begin
            check("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
            if (out_valid) begin
                if (sbq.size() == 0) begin
                    check("unexpected_out", 32'(out_data), 32'hDEAD);
                end else if (out_ready) begin
                    e = sbq.pop_front();
                    check("out_data", 32'(out_data), 32'(e.data));
                    check("out_beats", 32'(out_beats), 32'(e.beats));
                end else begin
                    check("stall_hold", 32'(out_data), 32'(sbq[0].data));
                end
            end
            if (out_valid && out_ready) run++;
            else run = 0;
            if (run > run_max) run_max = run;
        end
    end

    initial begin
        #3000000;
        check("global_timeout", 32'd1, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        logic [NP*16-1:0] va, vb, ones;
        int k;
        n_vec = 0; n_err = 0; run = 0; run_max = 0; t_waits = 0;
        model_on = 1'b0; done = 1'b0;
        model_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_acc = 1'b0; in_last = 1'b0;
        in_a = '0; in_b = '0; out_ready = 1'b1;
        for (int i = 0; i < NP; i++) ones[16*i +: 16] = 16'h3F80;

        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_beats", 32'(out_beats), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        // Single beat of eight 1.0*1.0 products, with latency measurement.
        push_exp(16'h4100, 1);
        send(ones, ones, 1'b0, 1'b0);
        k = 1;
        #1;
        while (!out_valid && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("latency", 32'(k), 32'(LAT));
        drain();

        // Three-beat accumulation group.
        push_exp(16'h41C0, 3);
        send(ones, ones, 1'b1, 1'b0);
        send(ones, ones, 1'b1, 1'b0);
        send(ones, ones, 1'b1, 1'b1);
        drain();

        // Cancellation across pairs: 3*1 + (-1)*1 = 2.
        va = '0; vb = '0;
        va[15:0] = 16'h4040; vb[15:0] = 16'h3F80;
        va[31:16] = 16'hBF80; vb[31:16] = 16'h3F80;
        push_exp(16'h4000, 1);
        send(va, vb, 1'b0, 1'b0);
        drain();

        // Ten streamed beats with a four-cycle downstream stall.
        model_on = 1'b1;
        t_waits = 0;
        fork
            for (int j = 1; j <= 10; j++) begin
                va = '0; vb = '0;
                va[15:0] = r2bf(real'(j)); vb[15:0] = 16'h3F80;
                send(va, vb, 1'b0, 1'b0);
            end
            begin
                repeat (6) @(negedge clk);
                out_ready = 1'b0;
                repeat (4) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        check("in_ready_dropped", 32'(t_waits > 0), 32'd1);
        drain();

        // Reset in the middle of an open group discards it.
        send(ones, ones, 1'b1, 1'b0);
        send(ones, ones, 1'b1, 1'b0);
        rst_n = 1'b0;
        sbq.delete();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        model_on = 1'b0;
        push_exp(16'h4100, 1);
        send(ones, ones, 1'b1, 1'b1);
        drain();

        // 64 back-to-back beats at full throughput.
        model_on = 1'b1;
        t_waits = 0;
        run_max = 0;
        for (int j = 0; j < 64; j++) begin
            for (int i = 0; i < NP; i++) begin
                va[16*i +: 16] = rnd_bf();
                vb[16*i +: 16] = rnd_bf();
            end
            send(va, vb, 1'b0, 1'b0);
        end
        check("t6_no_stall", 32'(t_waits), 32'd0);
        drain();
        check("t6_consecutive", 32'(run_max), 32'd64);

        // Randomized flags, gaps and backpressure.
        done = 1'b0;
        fork
            begin
                for (int j = 0; j < 400; j++) begin
                    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                    for (int i = 0; i < NP; i++) begin
                        va[16*i +: 16] = rnd_bf();
                        vb[16*i +: 16] = rnd_bf();
                    end
                    send(va, vb, 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 9) < 3));
                end
                send(va, vb, 1'b1, 1'b1);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
